// File: rtl/data_c_width_combin.sv
// ----------------------------------------------------------------------------
// data_c_width_combin
//
// Packs a stream of narrow "slaver" beats into wide "master" words. Each
// accepted beat is written into the next lane of an accumulator. A word is
// closed when every lane has been filled, or earlier when the beat carries
// slaver_last. The closed word is presented on a registered output stage.
// Lanes that were never filled read as zero, and master_keep marks the
// lanes that hold data.
//
// Configuration macro:
//   DATA_C_COMBIN_MSB_FIRST_EN - when defined, the first beat of a word lands
//                                in the top lane and keep fills from the MSB
//                                down. When undefined, the first beat lands in
//                                lane 0 and keep fills from bit 0 up. Timing
//                                is the same in both builds.
//
// Parameters:
//   ISIZE - slaver beat width in bits
//   RATIO - beats per master word (2..16)
//   OSIZE - master word width, fixed at ISIZE*RATIO
//
// Ports:
//   clock        - single clock, rising edge
//   rst          - synchronous active-high reset
//   slaver_valid - upstream beat valid
//   slaver_ready - block can take the upstream beat
//   slaver_data  - upstream beat data   [ISIZE-1:0]
//   slaver_last  - beat closes the frame (and the current word)
//   master_valid - packed word valid (registered)
//   master_ready - downstream takes the word
//   master_data  - packed word          [OSIZE-1:0] (registered)
//   master_keep  - per-lane valid flags [RATIO-1:0] (registered)
//   master_last  - word closes a frame (registered)
// ----------------------------------------------------------------------------
module data_c_width_combin #(
    parameter  int ISIZE = 8,
    parameter  int RATIO = 4,
    localparam int OSIZE = ISIZE * RATIO
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             slaver_valid,
    output logic             slaver_ready,
    input  logic [ISIZE-1:0] slaver_data,
    input  logic             slaver_last,
    output logic             master_valid,
    input  logic             master_ready,
    output logic [OSIZE-1:0] master_data,
    output logic [RATIO-1:0] master_keep,
    output logic             master_last
);

    localparam int CW = $clog2(RATIO);

    logic [CW-1:0]    r_cnt;
    logic [OSIZE-1:0] r_acc;
    logic [OSIZE-1:0] r_data;
    logic [RATIO-1:0] r_keep;
    logic             r_valid;
    logic             r_last;

    logic             w_accept;
    logic             w_done;
    logic [OSIZE-1:0] w_merged;
    logic [RATIO-1:0] w_keep;

    // The output register can take a new word whenever it is empty or is
    // being drained this very cycle, which lets completed words flow
    // back-to-back without a bubble.
    assign slaver_ready = !r_valid || master_ready;
    assign w_accept     = slaver_valid && slaver_ready;
    assign w_done       = w_accept && ((r_cnt == CW'(RATIO - 1)) || slaver_last);

    // Accumulator with the current beat dropped into its lane, plus the keep
    // mask covering every lane filled so far including the current one.
    // Lane selection is a compare per lane so no variable part-select is
    // needed.
    always_comb begin
        w_merged = r_acc;
        w_keep   = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (i == int'(r_cnt)) begin
`ifdef DATA_C_COMBIN_MSB_FIRST_EN
                w_merged[(RATIO-1-i)*ISIZE +: ISIZE] = slaver_data;
`else
                w_merged[i*ISIZE +: ISIZE] = slaver_data;
`endif
            end
            if (i <= int'(r_cnt)) begin
`ifdef DATA_C_COMBIN_MSB_FIRST_EN
                w_keep[RATIO-1-i] = 1'b1;
`else
                w_keep[i] = 1'b1;
`endif
            end
        end
    end

    // Lane counter, accumulator and output stage. A drain clears valid, but a
    // word completing in the same cycle overrides that, so the later
    // assignment to r_valid wins. On completion the accumulator is wiped so
    // that unfilled lanes of the next word read zero.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_data  <= '0;
            r_keep  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            if (r_valid && master_ready) begin
                r_valid <= 1'b0;
            end
            if (w_accept) begin
                if (w_done) begin
                    r_data  <= w_merged;
                    r_keep  <= w_keep;
                    r_last  <= slaver_last;
                    r_valid <= 1'b1;
                    r_cnt   <= '0;
                    r_acc   <= '0;
                end else begin
                    r_acc <= w_merged;
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign master_valid = r_valid;
    assign master_data  = r_data;
    assign master_keep  = r_keep;
    assign master_last  = r_last;

endmodule

// File: doc/data_c_width_combin.md
DATA_C_WIDTH_COMBIN -- requirements
Module: data_c_width_combin

Interface
REQ-001 The block SHALL have parameter ISIZE, default 8: slaver data width in bits.
REQ-002 The block SHALL have parameter RATIO, default 4: slaver beats packed per master word, legal range 2..16.
REQ-003 The block SHALL have derived parameter OSIZE, default ISIZE*RATIO: master data width, not overridable.
REQ-004 The block SHALL have port clock, input, 1: single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 The block SHALL have port slaver_valid, input, 1: upstream beat valid.
REQ-007 The block SHALL have port slaver_ready, output, 1: block accepts the upstream beat.
REQ-008 The block SHALL have port slaver_data, input, ISIZE: upstream beat data.
REQ-009 The block SHALL have port slaver_last, input, 1: final beat of a frame; closes the current word early.
REQ-010 The block SHALL have port master_valid, output, 1: packed word valid, registered.
REQ-011 The block SHALL have port master_ready, input, 1: downstream accepts the word.
REQ-012 The block SHALL have port master_data, output, OSIZE: packed word, registered.
REQ-013 The block SHALL have port master_keep, output, RATIO: per-lane valid flags, registered.
REQ-014 The block SHALL have port master_last, output, 1: word closes a frame, registered.

Function
REQ-015 A beat SHALL transfer on a cycle where valid and ready are both high; a word transfers likewise.
REQ-016 slaver_ready SHALL be high when master_valid is low or master_ready is high, and low otherwise; the path is combinational, with no dependence on slaver_valid/data/last.
REQ-017 Each accepted beat SHALL be written into lane cnt of an accumulator; lane-count cnt (0..RATIO-1) SHALL increment per accepted beat.
REQ-018 A word SHALL complete when the accepted beat has cnt==RATIO-1 or slaver_last=1.
REQ-019 On completion, the output register SHALL load the accumulator plus the current beat on the next edge; master_keep gets ones for lanes 0..cnt; master_last gets slaver_last; master_valid gets 1. Latency from the final-beat accept to master_valid SHALL be 1 cycle.
REQ-020 On completion, cnt SHALL return to 0 and accumulator lanes SHALL clear to 0; unfilled lanes of master_data SHALL read 0.
REQ-021 master_valid SHALL drop on a word handshake unless a new word loads in the same cycle; a simultaneous drain and load SHALL yield back-to-back words with no bubble.
REQ-022 With master_ready held high, throughput SHALL be one slaver beat per cycle with no stall.
REQ-023 master_data, master_keep and master_last SHALL hold stable while master_valid=1 and master_ready=0.
REQ-024 A single-beat frame (slaver_last on lane 0) SHALL produce keep=1 in lane 0 only.

Reset
REQ-025 While rst=1 at an edge, master_valid, master_data, master_keep, master_last, cnt and the accumulator SHALL clear to 0; slaver_ready SHALL read 1 in the following cycle.
REQ-026 Reset mid-word SHALL discard the partial word and any unaccepted output word, and SHALL not emit any of it afterward.

Configuration
REQ-027 Macro DATA_C_COMBIN_MSB_FIRST_EN SHALL control lane order.
REQ-028 Without DATA_C_COMBIN_MSB_FIRST_EN, the first beat of a word SHALL land in lane 0 (bits ISIZE-1:0), with keep bit 0 first.
REQ-029 With DATA_C_COMBIN_MSB_FIRST_EN, the first beat SHALL land in lane RATIO-1 (top bits), with keep filled from the MSB down; all timing SHALL be unchanged.

Verification (ISIZE=8, RATIO=4, macro off unless stated)
REQ-030 Full word: send 11,22,33,44 with master_ready=1 -> one cycle after the 4th accept: data=0x44332211, keep=1111, last=0.
REQ-031 Short frame: send AA, then BB with last=1 -> data=0x0000BBAA, keep=0011, last=1; the next word starts in lane 0.
REQ-032 Backpressure: hold master_ready=0 after the first word completes -> slaver_ready=0; the word is held stable; releasing ready drains it and re-asserts slaver_ready the same cycle.
REQ-033 Streaming: 8 consecutive beats 01..08 with master_ready=1 -> words 0x04030201 then 0x08070605 on consecutive 4-cycle boundaries, no slaver_ready drop.
REQ-034 Reset: pulse rst after 2 beats, then send 4 beats 55..88 -> only 0x88776655 is emitted.
REQ-035 Macro on: send 11,22,33,44 -> data=0x11223344, keep=1111; for 2-beat frame AA,BB(last) -> data=0xAABB0000, keep=1100.
